// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: decodes RISC-V style load/store codes, runs one
// bus transaction per op with a timeout, and returns extended load data.
module lsu_mem_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [2:0]  rd_en,
    input  logic [2:0]  wr_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        access_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_mask,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] RdLb  = 3'b001;
    localparam logic [2:0] RdLbu = 3'b010;
    localparam logic [2:0] RdLh  = 3'b011;
    localparam logic [2:0] RdLhu = 3'b100;
    localparam logic [2:0] RdLw  = 3'b101;
    localparam logic [2:0] WrSb  = 3'b001;
    localparam logic [2:0] WrSh  = 3'b010;
    localparam logic [2:0] WrSw  = 3'b011;
    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        resp_valid_q, resp_valid_d;
    logic        access_err_q, access_err_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        we_q, we_d;
    logic [31:0] maddr_q, maddr_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] mwdata_q, mwdata_d;
    logic [2:0]  rd_q, rd_d;
    logic [1:0]  lane_q, lane_d;

    logic        active, illegal, misaligned, is_half, is_word;
    logic [3:0]  st_mask;
    logic [31:0] st_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;

    // Request decode
    always_comb begin
        active     = (rd_en != 3'b000) || (wr_en != 3'b000);
        illegal    = ((rd_en != 3'b000) && (wr_en != 3'b000)) || (rd_en == 3'b110) ||
                     (rd_en == 3'b111) || wr_en[2];
        is_half    = (rd_en == RdLh) || (rd_en == RdLhu) || (wr_en == WrSh);
        is_word    = (rd_en == RdLw) || (wr_en == WrSw);
        misaligned = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
        case (wr_en)
            WrSb:    st_mask = 4'b0001 << addr[1:0];
            WrSh:    st_mask = addr[1] ? 4'b1100 : 4'b0011;
            default: st_mask = 4'b1111;
        endcase
        case (wr_en)
            WrSb:    st_data = {4{wdata[7:0]}};
            WrSh:    st_data = {2{wdata[15:0]}};
            default: st_data = wdata;
        endcase
    end

    // Load lane extraction from the bus word
    always_comb begin
        case (lane_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (rd_q)
            RdLb:    load_val = {{24{byte_sel[7]}}, byte_sel};
            RdLbu:   load_val = {24'h0, byte_sel};
            RdLh:    load_val = {{16{half_sel[15]}}, half_sel};
            RdLhu:   load_val = {16'h0, half_sel};
            default: load_val = mem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        access_err_d = 1'b0;
        bus_err_d    = 1'b0;
        rdata_d      = rdata_q;
        we_d         = we_q;
        maddr_d      = maddr_q;
        mask_d       = mask_q;
        mwdata_d     = mwdata_q;
        rd_d         = rd_q;
        lane_d       = lane_q;
        case (state_q)
            StIdle: begin
                if (req_valid && active) begin
                    if (illegal || misaligned) begin
                        state_d      = StResp;
                        resp_valid_d = 1'b1;
                        access_err_d = 1'b1;
                    end else begin
                        state_d  = StBus;
                        cnt_d    = 8'd0;
                        we_d     = (wr_en != 3'b000);
                        maddr_d  = {addr[31:2], 2'b00};
                        mask_d   = st_mask;
                        mwdata_d = st_data;
                        rd_d     = rd_en;
                        lane_d   = addr[1:0];
                    end
                end
            end
            StBus: begin
                // A ready on the final timeout cycle still completes normally
                if (mem_ready) begin
                    if (rd_q != 3'b000) begin
                        rdata_d = load_val;
                    end
                    state_d      = StResp;
                    resp_valid_d = 1'b1;
                end else if (cnt_q == CntLast) begin
                    state_d      = StResp;
                    resp_valid_d = 1'b1;
                    bus_err_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= 8'd0;
            resp_valid_q <= 1'b0;
            access_err_q <= 1'b0;
            bus_err_q    <= 1'b0;
            rdata_q      <= 32'h0;
            we_q         <= 1'b0;
            maddr_q      <= 32'h0;
            mask_q       <= 4'h0;
            mwdata_q     <= 32'h0;
            rd_q         <= 3'b000;
            lane_q       <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            access_err_q <= access_err_d;
            bus_err_q    <= bus_err_d;
            rdata_q      <= rdata_d;
            we_q         <= we_d;
            maddr_q      <= maddr_d;
            mask_q       <= mask_d;
            mwdata_q     <= mwdata_d;
            rd_q         <= rd_d;
            lane_q       <= lane_d;
        end
    end

    always_comb begin
        stall      = ((state_q == StIdle) && req_valid && active) || (state_q == StBus);
        resp_valid = resp_valid_q;
        access_err = access_err_q;
        bus_err    = bus_err_q;
        rdata      = rdata_q;
        mem_req    = (state_q == StBus);
        mem_we     = mem_req ? we_q : 1'b0;
        mem_addr   = mem_req ? maddr_q : 32'h0;
        mem_mask   = mem_req ? mask_q : 4'h0;
        mem_wdata  = mem_req ? mwdata_q : 32'h0;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 16, maximum cycles in BUS awaiting mem_ready (legal range 2..255).
REQ-002 SHALL have ports, one per line (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  pipeline presents a memory op
- rd_en  in  3  load code: 000 none, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW
- wr_en  in  3  store code: 000 none, 001 SB, 010 SH, 011 SW
- addr  in  32  effective byte address
- wdata  in  32  store source register value
- stall  out  1  hold pipeline
- resp_valid  out  1  one-cycle completion pulse
- rdata  out  32  extended load result
- access_err  out  1  misaligned or illegal op, qualified by resp_valid
- bus_err  out  1  timeout, qualified by resp_valid
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  32  word address: addr[31:2], 2'b00
- mem_mask  out  4  byte-lane enables
- mem_wdata  out  32  lane-replicated store data
- mem_ready  in  1  bus completion
- mem_rdata  in  32  bus read word
REQ-003 SHALL use one clock (clk); reset rst SHALL be synchronous and active-high.

Function
REQ-004 SHALL implement FSM states IDLE, BUS, RESP.
REQ-005 Op is active when rd_en!=000 or wr_en!=000.
REQ-006 Op is illegal when both codes are nonzero, rd_en is 110/111, or wr_en is 1xx.
REQ-007 Op is misaligned when:
- halfword (LH/LHU/SH) with addr[0]=1
- word (LW/SW) with addr[1:0]!=00
REQ-008 stall SHALL be combinational: (IDLE & req_valid & active) | BUS; stall SHALL be 0 in RESP.
REQ-009 IDLE & req_valid & active & (illegal|misaligned): next state RESP with access_err=1; no bus access.
REQ-010 IDLE & req_valid & active & legal: latch op/addr/wdata; next state BUS.
REQ-011 In BUS, mem_req=1; mem_we/mem_addr/mem_mask/mem_wdata SHALL be driven from latched values and held stable until exit.
REQ-012 BUS & mem_ready=1: capture load data; next state RESP; bus_err=0.
REQ-013 Timeout counter SHALL clear on BUS entry and increment each BUS cycle without mem_ready.
REQ-014 If counter reaches TIMEOUT-1 without mem_ready: next state RESP with bus_err=1; rdata unchanged.
REQ-015 mem_ready on the same cycle as timeout SHALL win (normal completion).
REQ-016 RESP SHALL last exactly one cycle: resp_valid=1, then IDLE; req_valid SHALL be ignored in RESP.
REQ-017 Minimum latency: accept cycle N, BUS N+1 with mem_ready=1, resp_valid at N+2.
REQ-018 Store mask: SB = 0001<<addr[1:0]; SH = 0011<<(2*addr[1]); SW = 1111. Loads drive mask 1111 and mem_we=0.
REQ-019 Store data: SB = {4{wdata[7:0]}}; SH = {2{wdata[15:0]}}; SW = wdata.
REQ-020 Load extraction: byte lane addr[1:0], halfword lane addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
REQ-021 rdata SHALL be registered and updated only on successful load completion; it holds otherwise.
REQ-022 access_err and bus_err SHALL be 0 whenever resp_valid=0.
REQ-023 mem_ready outside BUS SHALL be ignored.
REQ-024 A store completing SHALL pulse resp_valid and leave rdata unchanged.

Reset
REQ-025 rst=1 SHALL force IDLE, clear counter and latches, and drive rdata=0 and all outputs 0 (except combinational stall) at the next edge.
REQ-026 rst asserted in BUS or RESP SHALL abort the op: mem_req=0 next cycle, no resp_valid.

Verification
REQ-027 LB addr=0x1003, mem_rdata=0x80FF_1234, ready in first BUS cycle -> mem_addr=0x1000; resp_valid at N+2; rdata=0xFFFF_FF80.
REQ-028 SH addr=0x2002, wdata=0x0000_BEEF -> mem_we=1, mem_mask=1100, mem_wdata=0xBEEF_BEEF; rdata unchanged.
REQ-029 LW addr=0x3001 -> no mem_req; resp_valid at N+1 with access_err=1; rd_en=001 and wr_en=011 together -> same response.
REQ-030 LHU addr=0x4002, mem_ready never asserted, TIMEOUT=16 -> mem_req high 16 cycles; resp_valid with bus_err=1; rdata held.
REQ-031 LW, mem_ready after 3 BUS cycles -> stall high 4 cycles, mem_addr/mask stable throughout, rdata=mem_rdata.
REQ-032 rst pulsed during BUS -> IDLE, mem_req=0, no resp_valid, rdata=0; next LBU addr=0x5001, rdata_word=0x0000_AB00 -> rdata=0x0000_00AB.
